// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: reset PC default, NOP encoding, fetch FSM encoding
// and the major opcode[6:2] values of control-flow instructions.
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2
   } fetch_state_e;

   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: a taken redirect beats sequential advance, otherwise the PC holds.
module pc_next_mux #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] target_in,
   input  logic            redirect_in,
   input  logic            advance_in,
   output logic [XLEN-1:0] next_pc_out
);

   always_comb begin
      next_pc_out = pc_in;
      if (redirect_in) begin
         next_pc_out = target_in;
      end else if (advance_in) begin
         next_pc_out = pc_in + XLEN'(4);
      end
   end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch unit: owns the PC, issues one outstanding imem request at a time, redirects on
// taken branches (dropping stale fetches) and feeds decode through a one-entry register.
module fetch_redirect_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          XLEN     = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            branch_taken_in,
   input  logic [XLEN-1:0] branch_target_in,
   input  logic            stall_in,
   output logic            imem_req_valid_out,
   input  logic            imem_req_ready_in,
   output logic [XLEN-1:0] imem_addr_out,
   input  logic            imem_resp_valid_in,
   input  logic [XLEN-1:0] imem_rdata_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] instr_pc_out,
   output logic            instr_valid_out,
   output logic            misaligned_trap_out,
   output logic [XLEN-1:0] misaligned_addr_out,
   output logic [1:0]      fetch_state_out
);

   // Request channel: imem_req_valid_out stays high with imem_addr_out stable until a cycle
   // where imem_req_ready_in is also high; that cycle is the transfer. Responses arrive in
   // order, one per transfer, as a single-cycle imem_resp_valid_in pulse.

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic            drop_q, drop_d;
   logic            stale_q, stale_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic            instr_valid_q, instr_valid_d;
   logic            buf_valid_q, buf_valid_d;
   logic [XLEN-1:0] buf_q, buf_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic            trap_q, trap_d;
   logic [XLEN-1:0] trap_addr_q, trap_addr_d;

   logic            redirect;
   logic            misaligned;
   logic            req_fire;
   logic            can_load;
   logic            advance;
   logic [XLEN-1:0] next_pc;

   assign misaligned = branch_taken_in & is_misaligned(branch_target_in);
   assign redirect   = branch_taken_in & ~is_misaligned(branch_target_in);
   assign req_fire   = (state_q == FS_REQ) & imem_req_ready_in;
   assign can_load   = ~instr_valid_q | ~stall_in;
   // The PC steps only for a live response; a parked response already stepped it.
   assign advance    = (state_q == FS_WAIT) & ~buf_valid_q & imem_resp_valid_in &
                       ~drop_q & ~redirect;

   pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
      .pc_in       (pc_q),
      .target_in   (branch_target_in),
      .redirect_in (redirect),
      .advance_in  (advance),
      .next_pc_out (next_pc)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = next_pc;
      req_addr_d    = req_addr_q;
      drop_d        = drop_q;
      stale_d       = stale_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q & stall_in;
      buf_valid_d   = buf_valid_q;
      buf_d         = buf_q;
      buf_pc_d      = buf_pc_q;
      trap_d        = misaligned;
      trap_addr_d   = misaligned ? branch_target_in : trap_addr_q;

      case (state_q)
         FS_IDLE: begin
            state_d = FS_REQ;
         end
         FS_REQ: begin
            // A redirect cannot retract a presented request; mark it so its data is dropped.
            if (req_fire) begin
               state_d = FS_WAIT;
               stale_d = 1'b0;
               drop_d  = stale_q | redirect;
            end else if (redirect) begin
               stale_d = 1'b1;
            end
         end
         FS_WAIT: begin
            if (buf_valid_q) begin
               if (redirect) begin
                  buf_valid_d = 1'b0;
                  state_d     = FS_REQ;
               end else if (can_load) begin
                  instr_d       = buf_q;
                  instr_pc_d    = buf_pc_q;
                  instr_valid_d = 1'b1;
                  buf_valid_d   = 1'b0;
                  state_d       = FS_REQ;
               end
            end else if (imem_resp_valid_in) begin
               if (drop_q | redirect) begin
                  drop_d  = 1'b0;
                  state_d = FS_REQ;
               end else if (can_load) begin
                  instr_d       = imem_rdata_in;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  state_d       = FS_REQ;
               end else begin
                  buf_valid_d = 1'b1;
                  buf_d       = imem_rdata_in;
                  buf_pc_d    = pc_q;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase

      if (redirect) begin
         instr_valid_d = 1'b0;
      end

      if ((state_d == FS_REQ) && (state_q != FS_REQ)) begin
         req_addr_d = next_pc;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q       <= FS_IDLE;
         pc_q          <= RESET_PC;
         req_addr_q    <= RESET_PC;
         drop_q        <= 1'b0;
         stale_q       <= 1'b0;
         instr_q       <= XLEN'(NOP_INSTR);
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         buf_valid_q   <= 1'b0;
         buf_q         <= '0;
         buf_pc_q      <= '0;
         trap_q        <= 1'b0;
         trap_addr_q   <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_addr_q    <= req_addr_d;
         drop_q        <= drop_d;
         stale_q       <= stale_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         buf_valid_q   <= buf_valid_d;
         buf_q         <= buf_d;
         buf_pc_q      <= buf_pc_d;
         trap_q        <= trap_d;
         trap_addr_q   <= trap_addr_d;
      end
   end

   assign imem_req_valid_out  = (state_q == FS_REQ);
   assign imem_addr_out       = req_addr_q;
   assign instr_out           = instr_q;
   assign instr_pc_out        = instr_pc_q;
   assign instr_valid_out     = instr_valid_q;
   assign misaligned_trap_out = trap_q;
   assign misaligned_addr_out = trap_addr_q;
   assign fetch_state_out     = state_q;

endmodule
